fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage plus IF/ID pipeline register: the producer end of the decode stage's `Instruction` input and the consumer of its stall (`hazard_detected`, `freeze`) and branch-redirect signals. It owns the program counter and drives a variable-latency instruction-memory request/ready port. It buffers one fetched word across stalls and discards in-flight or wrong-path fetches on a taken branch.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `hazard_detected` in 1: stall from the hazard unit.
- `freeze` in 1: stall from decode for multi-cycle instructions.
- `br_taken` in 1: taken branch resolved in EXE.
- `br_addr` in 32: branch target, valid when `br_taken`=1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: word-aligned fetch address, bits [1:0] always 0.
- `imem_ready` in 1: `imem_rdata` valid; completes the current request.
- `imem_rdata` in 32: fetched instruction word.
- `Instruction` out 32: IF/ID instruction register.
- `PC` out 32: IF/ID register, address of `Instruction` + 4.
- `valid` out 1: `Instruction` is a real fetched word; 0 means bubble.

## Operation
- `stall` = `hazard_detected` | `freeze`. `br_taken` overrides `stall` everywhere.
- Registers: `pc`, `kill_addr`, `skid` (32-bit word), and state.
- Request rule: `imem_req`=1 in FETCH and KILL. In KILL, `imem_addr`=`kill_addr`; otherwise `imem_addr`=`pc`. Once `imem_req` rises, the address stays stable until `imem_ready`.
- A bubble sets `Instruction`=0 (NOP), `PC`=0 and `valid`=0.
- States:
  - IDLE: reset state, `imem_req`=0. On the next edge, go to FETCH.
  - FETCH, with `br_taken`: `pc`<=`br_addr`, IF/ID<=bubble. If `imem_ready`=1, discard the data and stay in FETCH. Otherwise `kill_addr`<=`pc` and go to KILL.
  - FETCH, with `imem_ready` and no `stall`: IF/ID<={`imem_rdata`, `pc`+4, 1}, `pc`<=`pc`+4, stay in FETCH.
  - FETCH, with `imem_ready` and `stall`: `skid`<=`imem_rdata`, IF/ID holds, go to HOLD.
  - FETCH, with no `imem_ready` and `stall`: IF/ID holds.
  - FETCH, with no `imem_ready` and no `stall`: IF/ID<=bubble.
  - HOLD: `imem_req`=0. With `br_taken`: drop `skid`, `pc`<=`br_addr`, IF/ID<=bubble, go to FETCH. Else with `stall`: hold everything. Else: IF/ID<={`skid`, `pc`+4, 1}, `pc`<=`pc`+4, go to FETCH.
  - KILL: the old request is drained and its data discarded. With `br_taken`: `pc`<=`br_addr`; IF/ID stays bubble. On `imem_ready`, go to FETCH.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. `br_addr`[1:0] is ignored and forced to 0.
- Reset mid-request: all state is cleared immediately and the outstanding memory response is not tracked. The memory must drop it when `imem_req` falls.

## Timing
- Reset values: `Instruction`=0, `PC`=0, `valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, state IDLE, `pc`=`RESET_PC`.
- First `imem_req` is in the first cycle after the first edge with `rst`=1.
- With zero-wait memory (`imem_ready` tied high), throughput is one instruction per cycle. Fetch to `Instruction` is one cycle.
- Redirect penalty: the first target word appears in IF/ID 2 cycles after `br_taken` with zero-wait memory, plus the drain time if in KILL.
- A stall asserted in cycle N holds IF/ID at the edge ending cycle N. No word is lost or duplicated across any stall length.
- `imem_req`/`imem_addr` are registered-state decodes with no combinational path from `stall` or `br_taken`.

## Structure
- Shared pipeline package holds:
  - state enum (IDLE, FETCH, HOLD, KILL);
  - `NOP_WORD`=32'h0;
  - `WORD_BYTES`=4;
  - `XLEN`=32, also used by decode.
- One natural sub-module, `if_id_reg`: the IF/ID register with load, hold and flush controls. It is reused by the later pipeline-register blocks.

## Test plan
- Zero-wait memory, `RESET_PC`=0x100, release reset -> `imem_addr` 0x100, 0x104, 0x108 on consecutive cycles. `Instruction` follows one cycle later with `PC`=0x104, 0x108 and `valid`=1.
- `hazard_detected` high for 3 cycles while `imem_ready`=1 -> state HOLD and IF/ID frozen. After release, the skid word appears next with `PC` incremented exactly once: no loss, no duplicate.
- `imem_ready` delayed 4 cycles, `br_taken`=1 with `br_addr`=0x200 in cycle 1 of the wait -> `imem_addr` stays at the old address until ready and the old data is discarded. The next request is to 0x200, and `valid` stays 0 until the 0x200 word lands.
- `br_taken` and `freeze` together in HOLD -> `skid` dropped, IF/ID bubble, next fetch 0x200.
- `pc`=0xFFFF_FFFC, one fetch -> `PC`=0 and next `imem_addr`=0.
- `rst` low while `imem_req`=1 and memory waiting -> `imem_req`=0 and `valid`=0 immediately, asynchronously. Refetch starts from `RESET_PC` after release.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
// Holds the fetch FSM encoding, word constants and the XLEN width.
package fetch_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] WORD_BYTES = 32'd4;
   localparam logic [XLEN-1:0] NOP_WORD   = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      KILL  = 2'd3
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(
      input logic [XLEN-1:0] a
   );
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with load, hold and flush.
// Flush wins over load and turns the slot into a NOP bubble.
module if_id_reg
   import fetch_unit_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic            valid_o
);

   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;

   // Select flush, load or hold for the register slot.
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (flush_i) begin
         instr_d = NOP_WORD;
         pc_d    = '0;
         valid_d = 1'b0;
      end else if (load_i) begin
         instr_d = instr_i;
         pc_d    = pc_i;
         valid_d = 1'b1;
      end
   end

   // Register the slot; reset leaves a bubble.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         instr_q <= NOP_WORD;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives imem, feeds IF/ID.
// Buffers one word across stalls and drains wrong-path fetches.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hazard_detected,
   input  logic            freeze,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_addr,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] Instruction,
   output logic [XLEN-1:0] PC,
   output logic            valid
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] kill_addr_q, kill_addr_d;
   logic [XLEN-1:0] skid_q, skid_d;

   logic            stall;
   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] pc_inc;
   logic            ifid_load;
   logic            ifid_flush;
   logic [XLEN-1:0] ifid_instr;

   assign stall  = hazard_detected | freeze;
   assign br_tgt = word_align(br_addr);
   assign pc_inc = pc_q + WORD_BYTES;

   // Request side decodes only registered state.
   assign imem_req  = (state_q == FETCH) || (state_q == KILL);
   assign imem_addr = (state_q == KILL) ? kill_addr_q : pc_q;

   // Next-state and IF/ID control; a branch overrides any stall.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_addr_d = kill_addr_q;
      skid_d      = skid_q;
      ifid_load   = 1'b0;
      ifid_flush  = 1'b0;
      ifid_instr  = imem_rdata;
      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (br_taken) begin
               pc_d       = br_tgt;
               ifid_flush = 1'b1;
               if (!imem_ready) begin
                  kill_addr_d = pc_q;
                  state_d     = KILL;
               end
            end else if (imem_ready) begin
               if (stall) begin
                  skid_d  = imem_rdata;
                  state_d = HOLD;
               end else begin
                  ifid_load = 1'b1;
                  pc_d      = pc_inc;
               end
            end else if (!stall) begin
               ifid_flush = 1'b1;
            end
         end
         HOLD: begin
            if (br_taken) begin
               pc_d       = br_tgt;
               ifid_flush = 1'b1;
               state_d    = FETCH;
            end else if (!stall) begin
               ifid_load  = 1'b1;
               ifid_instr = skid_q;
               pc_d       = pc_inc;
               state_d    = FETCH;
            end
         end
         KILL: begin
            ifid_flush = 1'b1;
            if (br_taken) begin
               pc_d = br_tgt;
            end
            if (imem_ready) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Fetch-side state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         kill_addr_q <= RESET_PC;
         skid_q      <= NOP_WORD;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_addr_q <= kill_addr_d;
         skid_q      <= skid_d;
      end
   end

   if_id_reg u_if_id (
      .clk_i   (clk),
      .rst_ni  (rst),
      .load_i  (ifid_load),
      .flush_i (ifid_flush),
      .instr_i (ifid_instr),
      .pc_i    (pc_inc),
      .instr_o (Instruction),
      .pc_o    (PC),
      .valid_o (valid)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus
// random stalls, branches and memory latency against a stream model.
module tb_fetch_unit;

   localparam logic [31:0] RP = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        hazard_detected;
   logic        freeze;
   logic        br_taken;
   logic [31:0] br_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] Instruction;
   logic [31:0] PC;
   logic        valid;

   int n_chk  = 0;
   int n_pass = 0;

   int mem_lat  = 0;
   bit mem_rand = 1'b0;
   int lat_cnt  = -1;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RP)) dut (
      .clk             (clk),
      .rst             (rst),
      .hazard_detected (hazard_detected),
      .freeze          (freeze),
      .br_taken        (br_taken),
      .br_addr         (br_addr),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .Instruction     (Instruction),
      .PC              (PC),
      .valid           (valid)
   );

   // Program image: a bijective address-to-word mapping.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   // Memory model: each request completes after mem_lat wait cycles.
   initial begin
      imem_ready = 1'b0;
      imem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!imem_req) begin
            lat_cnt    = -1;
            imem_ready = 1'b0;
            imem_rdata = '0;
         end else begin
            if (lat_cnt < 0)
               lat_cnt = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
            if (lat_cnt == 0) begin
               imem_ready = 1'b1;
               imem_rdata = memf(imem_addr);
               lat_cnt    = -1;
            end else begin
               imem_ready = 1'b0;
               imem_rdata = '0;
               lat_cnt    = lat_cnt - 1;
            end
         end
      end
   end

   task automatic quiet();
      hazard_detected = 1'b0;
      freeze          = 1'b0;
      br_taken        = 1'b0;
      br_addr         = '0;
   endtask

   // Reset, then release just after an edge; ends in the IDLE cycle.
   task automatic do_reset();
      rst = 1'b0;
      quiet();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      quiet();
      mem_lat  = 0;
      mem_rand = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (Instruction !== 32'h0)
         $display("FAIL rst_instr got %h want 0", Instruction);
      else n_pass++;
      n_chk++;
      if (PC !== 32'h0) $display("FAIL rst_pc got %h want 0", PC);
      else n_pass++;
      n_chk++;
      if (valid !== 1'b0) $display("FAIL rst_valid got %b want 0", valid);
      else n_pass++;
      n_chk++;
      if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req);
      else n_pass++;
      n_chk++;
      if (imem_addr !== RP)
         $display("FAIL rst_addr got %h want %h", imem_addr, RP);
      else n_pass++;
      tick();
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if (imem_req !== 1'b0) $display("FAIL idle_req got %b want 0", imem_req);
      else n_pass++;
   endtask

   task automatic test_stream();
      for (int c = 1; c <= 3; c++) begin
         logic [31:0] ea;
         ea = RP + 32'(4 * (c - 1));
         tick();
         @(negedge clk);
         n_chk++;
         if ({imem_req, imem_addr} !== {1'b1, ea})
            $display("FAIL stream_addr c%0d got %b/%h want 1/%h",
                     c, imem_req, imem_addr, ea);
         else n_pass++;
         n_chk++;
         if (c == 1) begin
            if (valid !== 1'b0)
               $display("FAIL stream_valid0 got %b want 0", valid);
            else n_pass++;
         end else begin
            if ({valid, PC, Instruction} !== {1'b1, ea, memf(ea - 32'd4)})
               $display("FAIL stream_ifid c%0d got %b/%h/%h want 1/%h/%h",
                        c, valid, PC, Instruction, ea, memf(ea - 32'd4));
            else n_pass++;
         end
      end
   endtask

   task automatic test_hazard();
      logic [31:0] w108;
      w108 = memf(32'h108);
      for (int c = 4; c <= 7; c++) begin
         tick();
         hazard_detected = (c <= 6);
         @(negedge clk);
         n_chk++;
         if ({valid, PC, Instruction} !== {1'b1, 32'h10C, w108})
            $display("FAIL hazard_hold c%0d got %b/%h/%h want 1/10c/%h",
                     c, valid, PC, Instruction, w108);
         else n_pass++;
         n_chk++;
         if (imem_req !== (c == 4))
            $display("FAIL hazard_req c%0d got %b want %b",
                     c, imem_req, (c == 4));
         else n_pass++;
      end
      tick();
      @(negedge clk);
      n_chk++;
      if ({valid, PC, Instruction} !== {1'b1, 32'h110, memf(32'h10C)})
         $display("FAIL hazard_skid got %b/%h/%h want 1/110/%h",
                  valid, PC, Instruction, memf(32'h10C));
      else n_pass++;
      n_chk++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h110})
         $display("FAIL hazard_refetch got %b/%h want 1/110",
                  imem_req, imem_addr);
      else n_pass++;
      tick();
      @(negedge clk);
      n_chk++;
      if ({valid, PC, Instruction} !== {1'b1, 32'h114, memf(32'h110)})
         $display("FAIL hazard_next got %b/%h/%h want 1/114/%h",
                  valid, PC, Instruction, memf(32'h110));
      else n_pass++;
   endtask

   task automatic test_kill();
      mem_lat = 4;
      do_reset();
      tick();
      br_taken = 1'b1;
      br_addr  = 32'h200;
      @(negedge clk);
      n_chk++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h100})
         $display("FAIL kill_first got %b/%h want 1/100", imem_req, imem_addr);
      else n_pass++;
      for (int c = 2; c <= 10; c++) begin
         logic [31:0] ea;
         ea = (c <= 5) ? 32'h100 : 32'h200;
         tick();
         quiet();
         @(negedge clk);
         n_chk++;
         if ({imem_req, imem_addr, valid} !== {1'b1, ea, 1'b0})
            $display("FAIL kill_wait c%0d got %b/%h/%b want 1/%h/0",
                     c, imem_req, imem_addr, valid, ea);
         else n_pass++;
      end
      tick();
      @(negedge clk);
      n_chk++;
      if ({valid, PC, Instruction} !== {1'b1, 32'h204, memf(32'h200)})
         $display("FAIL kill_land got %b/%h/%h want 1/204/%h",
                  valid, PC, Instruction, memf(32'h200));
      else n_pass++;
   endtask

   task automatic test_br_hold();
      mem_lat = 0;
      do_reset();
      tick();
      tick();
      freeze = 1'b1;
      tick();
      br_taken = 1'b1;
      br_addr  = 32'h203;
      @(negedge clk);
      n_chk++;
      if ({imem_req, valid} !== 2'b01)
         $display("FAIL brhold_hold got %b/%b want 0/1", imem_req, valid);
      else n_pass++;
      tick();
      quiet();
      @(negedge clk);
      n_chk++;
      if ({imem_req, imem_addr, valid, PC, Instruction} !==
          {1'b1, 32'h200, 1'b0, 32'h0, 32'h0})
         $display("FAIL brhold_bubble got %b/%h/%b/%h/%h want 1/200/0/0/0",
                  imem_req, imem_addr, valid, PC, Instruction);
      else n_pass++;
      tick();
      @(negedge clk);
      n_chk++;
      if ({valid, PC, Instruction} !== {1'b1, 32'h204, memf(32'h200)})
         $display("FAIL brhold_land got %b/%h/%h want 1/204/%h",
                  valid, PC, Instruction, memf(32'h200));
      else n_pass++;
   endtask

   task automatic test_wrap();
      tick();
      br_taken = 1'b1;
      br_addr  = 32'hFFFF_FFFC;
      tick();
      quiet();
      @(negedge clk);
      n_chk++;
      if ({imem_addr, valid} !== {32'hFFFF_FFFC, 1'b0})
         $display("FAIL wrap_addr got %h/%b want fffffffc/0", imem_addr, valid);
      else n_pass++;
      tick();
      @(negedge clk);
      n_chk++;
      if ({valid, PC, Instruction, imem_addr} !==
          {1'b1, 32'h0, memf(32'hFFFF_FFFC), 32'h0})
         $display("FAIL wrap_pc got %b/%h/%h/%h want 1/0/%h/0",
                  valid, PC, Instruction, imem_addr, memf(32'hFFFF_FFFC));
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      mem_lat = 0;
      do_reset();
      tick();
      @(negedge clk);
      mem_lat = 4;
      tick();
      @(negedge clk);
      n_chk++;
      if ({valid, imem_req, imem_ready} !== 3'b110)
         $display("FAIL rmid_pre got %b/%b/%b want 1/1/0",
                  valid, imem_req, imem_ready);
      else n_pass++;
      #1 rst = 1'b0;
      #1;
      n_chk++;
      if ({imem_req, valid, PC, Instruction, imem_addr} !==
          {1'b0, 1'b0, 32'h0, 32'h0, RP})
         $display("FAIL rmid_async got %b/%b/%h/%h/%h want 0/0/0/0/%h",
                  imem_req, valid, PC, Instruction, imem_addr, RP);
      else n_pass++;
      mem_lat = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      tick();
      @(negedge clk);
      n_chk++;
      if ({imem_req, imem_addr} !== {1'b1, RP})
         $display("FAIL rmid_refetch got %b/%h want 1/%h", imem_req, imem_addr, RP);
      else n_pass++;
      tick();
      @(negedge clk);
      n_chk++;
      if ({valid, PC, Instruction} !== {1'b1, RP + 32'd4, memf(RP)})
         $display("FAIL rmid_land got %b/%h/%h want 1/%h/%h",
                  valid, PC, Instruction, RP + 32'd4, memf(RP));
      else n_pass++;
   endtask

   // Stream model: decode consumes IF/ID when not stalled and no branch.
   // Consumed words must follow program order from the last redirect.
   task automatic test_random();
      logic [31:0] exp_pc;
      logic        prev_wait;
      logic [31:0] prev_addr;
      int          consumed;
      mem_rand  = 1'b1;
      do_reset();
      exp_pc    = RP + 32'd4;
      prev_wait = 1'b0;
      prev_addr = '0;
      consumed  = 0;
      for (int i = 0; i < 600; i++) begin
         tick();
         hazard_detected = ($urandom_range(0, 99) < 20);
         freeze          = ($urandom_range(0, 99) < 15);
         br_taken        = ($urandom_range(0, 99) < 7);
         br_addr         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF9
                                                       : $urandom;
         @(negedge clk);
         if (imem_req) begin
            n_chk++;
            if (imem_addr[1:0] !== 2'b00)
               $display("FAIL rnd_align i%0d got %h", i, imem_addr);
            else n_pass++;
         end
         if (prev_wait) begin
            n_chk++;
            if ({imem_req, imem_addr} !== {1'b1, prev_addr})
               $display("FAIL rnd_stable i%0d got %b/%h want 1/%h",
                        i, imem_req, imem_addr, prev_addr);
            else n_pass++;
         end
         prev_wait = imem_req && !imem_ready;
         prev_addr = imem_addr;
         if (br_taken) begin
            exp_pc = {br_addr[31:2], 2'b00} + 32'd4;
         end else if (valid && !hazard_detected && !freeze) begin
            consumed++;
            n_chk++;
            if ({PC, Instruction} !== {exp_pc, memf(exp_pc - 32'd4)})
               $display("FAIL rnd_stream i%0d got %h/%h want %h/%h",
                        i, PC, Instruction, exp_pc, memf(exp_pc - 32'd4));
            else n_pass++;
            exp_pc = exp_pc + 32'd4;
         end
      end
      quiet();
      mem_rand = 1'b0;
      n_chk++;
      if (consumed < 30)
         $display("FAIL rnd_progress got %0d want >=30", consumed);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_hazard();
      test_kill();
      test_br_hold();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
